// File: rtl/uart_rx_word.sv
// uart_rx_word: 8N1 serial receiver with mid-bit sampling, byte reporting and
// pairing of bytes into 16-bit words (low byte first) behind a valid/ack handshake.
module uart_rx_word #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        serial_in,
    input  logic        rd_en,
    output logic [7:0]  byte_out,
    output logic        byte_valid,
    output logic [15:0] data_out,
    output logic        word_valid,
    output logic        overrun,
    output logic        frame_err,
    output logic        busy
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_END = CNT_W'((CLKS_PER_BIT - 1) / 2);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t           r_state, w_state_nxt;
    logic             r_sync1, r_sync2;
    logic             w_rx_s;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [2:0]       r_idx, w_idx_nxt;
    logic [7:0]       r_shift, w_shift_nxt;
    logic             w_byte_done;
    logic             w_frame_bad;
    logic             w_word_done;
    logic             r_hi;
    logic [7:0]       r_low;

    assign w_rx_s      = r_sync2;
    assign busy        = (r_state != S_IDLE);
    assign w_word_done = w_byte_done & r_hi;

    // Two-flop synchroniser; resets to the idle (high) line level so release never fakes a start bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= serial_in;
            r_sync2 <= r_sync1;
        end
    end

    // Receiver state, bit-timing counter, bit index and shift register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_shift <= w_shift_nxt;
        end
    end

    // Next-state logic: half-bit wait to confirm the start bit, then full-bit steps to each sample point.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_byte_done = 1'b0;
        w_frame_bad = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                w_idx_nxt = '0;
                if (!w_rx_s) begin
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (r_cnt == HALF_END) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = w_rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (r_cnt == BIT_END) begin
                    w_cnt_nxt          = '0;
                    w_shift_nxt[r_idx] = w_rx_s;
                    if (r_idx == 3'd7) begin
                        w_state_nxt = S_STOP;
                    end else begin
                        w_idx_nxt = r_idx + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (r_cnt == BIT_END) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                    if (w_rx_s) begin
                        w_byte_done = 1'b1;
                    end else begin
                        w_frame_bad = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Byte report and framing-error pulses, one cycle after the stop-bit sample.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_out   <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= w_byte_done;
            frame_err  <= w_frame_bad;
            if (w_byte_done) begin
                byte_out <= r_shift;
            end
        end
    end

    // Word assembler and consumer handshake; an acknowledge coinciding with a new word avoids overrun.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hi       <= 1'b0;
            r_low      <= '0;
            data_out   <= '0;
            word_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (w_byte_done) begin
                r_hi <= ~r_hi;
                if (!r_hi) begin
                    r_low <= r_shift;
                end
            end
            if (w_word_done) begin
                data_out   <= {r_shift, r_low};
                word_valid <= 1'b1;
                if (word_valid && !rd_en) begin
                    overrun <= 1'b1;
                end else if (word_valid && rd_en) begin
                    overrun <= 1'b0;
                end
            end else if (rd_en && word_valid) begin
                word_valid <= 1'b0;
                overrun    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_word.sv
// Directed bench for uart_rx_word with a byte/word scoreboard fed by the stimulus.
module tb_uart_rx_word;

    localparam int CPB = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        serial_in;
    logic        rd_en;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic [15:0] data_out;
    logic        word_valid;
    logic        overrun;
    logic        frame_err;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;
    int bv_cnt   = 0;
    int fe_cnt   = 0;

    logic [7:0]  exp_bytes[$];
    logic [15:0] exp_words[$];
    logic        sb_hi  = 1'b0;
    logic [7:0]  sb_lo  = 8'h00;
    logic        mon_hi = 1'b0;

    always #5 clk = ~clk;

    uart_rx_word #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst        (rst),
        .serial_in  (serial_in),
        .rd_en      (rd_en),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .data_out   (data_out),
        .word_valid (word_valid),
        .overrun    (overrun),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        serial_in = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_ok);
        if (stop_ok) begin
            exp_bytes.push_back(b);
            if (sb_hi) begin
                exp_words.push_back({b, sb_lo});
                sb_hi = 1'b0;
            end else begin
                sb_lo = b;
                sb_hi = 1'b1;
            end
        end
        serial_in = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            serial_in = b[i];
            repeat (CPB) @(negedge clk);
        end
        serial_in = stop_ok;
        repeat (CPB) @(negedge clk);
        serial_in = 1'b1;
    endtask

    task automatic pulse_rd();
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    // Scoreboard monitor: pops expected bytes/words when the DUT reports them.
    initial begin
        logic [7:0]  eb;
        logic [15:0] ew;
        forever begin
            @(negedge clk);
            if (rst !== 1'b1) begin
                mon_hi = 1'b0;
            end else begin
                if (frame_err === 1'b1) fe_cnt++;
                if (byte_valid === 1'b1) begin
                    bv_cnt++;
                    chk("byte_pending", 32'(exp_bytes.size() > 0), 32'd1);
                    if (exp_bytes.size() > 0) begin
                        eb = exp_bytes.pop_front();
                        chk("byte_out", 32'(byte_out), 32'(eb));
                    end
                    if (mon_hi) begin
                        mon_hi = 1'b0;
                        chk("word_pending", 32'(exp_words.size() > 0), 32'd1);
                        if (exp_words.size() > 0) begin
                            ew = exp_words.pop_front();
                            chk("word_data", 32'(data_out), 32'(ew));
                            chk("word_valid_rise", 32'(word_valid), 32'd1);
                        end
                    end else begin
                        mon_hi = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t_bv;
        int t_fe;
        int bad;
        int waited;

        rst       = 1'b0;
        serial_in = 1'b1;
        rd_en     = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_byte_out", 32'(byte_out), 32'h0);
        chk("rst_data_out", 32'(data_out), 32'h0);
        chk("rst_flags", 32'({byte_valid, word_valid, overrun, frame_err, busy}), 32'h0);
        rst = 1'b1;
        @(negedge clk);
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            if ((byte_out | data_out | {byte_valid, word_valid, overrun, frame_err, busy}) != 0) bad++;
            @(negedge clk);
        end
        chk("idle_quiet", 32'(bad), 32'd0);

        // Back-to-back 0x34, 0x12 then acknowledge.
        t_bv = bv_cnt;
        send_byte(8'h34, 1'b1);
        send_byte(8'h12, 1'b1);
        idle(6);
        chk("pair_bv_count", 32'(bv_cnt - t_bv), 32'd2);
        chk("pair_byte_out", 32'(byte_out), 32'h12);
        chk("pair_word_valid", 32'(word_valid), 32'd1);
        chk("pair_data_out", 32'(data_out), 32'h1234);
        pulse_rd();
        chk("pair_ack_clears", 32'(word_valid), 32'd0);
        chk("pair_no_overrun", 32'(overrun), 32'd0);

        // Two-cycle glitch must not start a frame.
        t_bv = bv_cnt;
        serial_in = 1'b0;
        repeat (2) @(negedge clk);
        serial_in = 1'b1;
        repeat (2) @(negedge clk);
        chk("glitch_busy", 32'(busy), 32'd1);
        waited = 2;
        while (busy === 1'b1 && waited < 12) begin
            @(negedge clk);
            waited++;
        end
        chk("glitch_busy_clears", 32'(waited <= 6), 32'd1);
        idle(10);
        chk("glitch_no_byte", 32'(bv_cnt - t_bv), 32'd0);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h5A, 1'b1);
        idle(6);
        chk("after_glitch_word", 32'(data_out), 32'h5AA5);
        pulse_rd();

        // Framing error leaves the assembler phase untouched.
        t_bv = bv_cnt;
        t_fe = fe_cnt;
        send_byte(8'h55, 1'b0);
        idle(20);
        chk("ferr_pulse_count", 32'(fe_cnt - t_fe), 32'd1);
        chk("ferr_no_byte", 32'(bv_cnt - t_bv), 32'd0);
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        idle(6);
        chk("ferr_phase_word", 32'(data_out), 32'h0201);
        chk("ferr_word_valid", 32'(word_valid), 32'd1);
        pulse_rd();

        // Overrun: two words without acknowledge.
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        send_byte(8'h44, 1'b1);
        idle(6);
        chk("ovr_data_out", 32'(data_out), 32'h4433);
        chk("ovr_word_valid", 32'(word_valid), 32'd1);
        chk("ovr_overrun", 32'(overrun), 32'd1);
        pulse_rd();
        chk("ovr_ack_wv", 32'(word_valid), 32'd0);
        chk("ovr_ack_ov", 32'(overrun), 32'd0);

        // Reset in the middle of data bit 4 with the assembler holding a low byte.
        send_byte(8'h99, 1'b1);
        idle(6);
        serial_in = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            serial_in = (i % 2 == 0) ? 1'b1 : 1'b0;
            repeat (CPB) @(negedge clk);
        end
        serial_in = 1'b1;
        repeat (3) @(negedge clk);
        rst   = 1'b0;
        sb_hi = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrst_byte_out", 32'(byte_out), 32'h0);
        chk("midrst_data_out", 32'(data_out), 32'h0);
        chk("midrst_flags", 32'({byte_valid, word_valid, overrun, frame_err, busy}), 32'h0);
        rst = 1'b1;
        t_bv = bv_cnt;
        idle(20);
        chk("midrst_no_stale", 32'(bv_cnt - t_bv), 32'd0);
        send_byte(8'h7E, 1'b1);
        send_byte(8'h81, 1'b1);
        idle(6);
        chk("midrst_word", 32'(data_out), 32'h817E);
        chk("midrst_byte", 32'(byte_out), 32'h81);
        chk("midrst_wv", 32'(word_valid), 32'd1);
        pulse_rd();

        chk("bytes_drained", 32'(exp_bytes.size()), 32'd0);
        chk("words_drained", 32'(exp_words.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
